// File: rtl/disp_msg_sched.sv
// Doorlock 4-digit 7-segment display scheduler: multiplexes the keypad-entry view
// with timed OPEN/FAIL messages and drives the digit commons and segments directly.
module disp_msg_sched #(
   parameter int unsigned SCAN_DIV    = 4096,
   parameter int unsigned HOLD_FRAMES = 256,
   parameter int unsigned MASK        = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_open,
   input  logic        req_fail,
   input  logic [2:0]  entry_len,
   input  logic [15:0] entry_digits,
   output logic        com5,
   output logic        com6,
   output logic        com7,
   output logic        com8,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        e,
   output logic        f,
   output logic        g,
   output logic        busy
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OPEN = 2'd1;
   localparam logic [1:0] ST_FAIL = 2'd2;

   // Segment vectors are {a,b,c,d,e,f,g}
   localparam logic [6:0] SEG_O    = 7'b1111110;
   localparam logic [6:0] SEG_P    = 7'b1100111;
   localparam logic [6:0] SEG_E    = 7'b1001111;
   localparam logic [6:0] SEG_N    = 7'b0010101;
   localparam logic [6:0] SEG_F    = 7'b1000111;
   localparam logic [6:0] SEG_A    = 7'b1110111;
   localparam logic [6:0] SEG_I    = 7'b0110000;
   localparam logic [6:0] SEG_L    = 7'b0001110;
   localparam logic [6:0] SEG_DASH = 7'b0000001;

   logic [1:0]    state, state_d;
   logic [PW-1:0] presc, presc_d;
   logic [1:0]    idx, idx_d;
   logic [HW-1:0] hold, hold_d;
   logic          frame_end;
   logic [3:0]    com_q, com_d;
   logic [6:0]    seg_q, seg_d;
   logic          busy_q, busy_d;

   function automatic logic [6:0] bcd_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // Glyph for one digit slot given the (next) state, slot index and entry data
   function automatic logic [6:0] slot_seg(input logic [1:0]  st,
                                           input logic [1:0]  ix,
                                           input logic [2:0]  len,
                                           input logic [15:0] dig);
      logic [6:0] s;
      logic [2:0] len_eff;
      logic [3:0] nib;
      s       = 7'b0000000;
      len_eff = (len > 3'd4) ? 3'd4 : len;
      nib     = dig[{ix, 2'b00} +: 4];
      case (st)
         ST_OPEN: begin
            case (ix)
               2'd0:    s = SEG_O;
               2'd1:    s = SEG_P;
               2'd2:    s = SEG_E;
               default: s = SEG_N;
            endcase
         end
         ST_FAIL: begin
            case (ix)
               2'd0:    s = SEG_F;
               2'd1:    s = SEG_A;
               2'd2:    s = SEG_I;
               default: s = SEG_L;
            endcase
         end
         default: begin
            if ({1'b0, ix} < len_eff)
               s = (MASK != 0) ? SEG_DASH : bcd_seg(nib);
         end
      endcase
      return s;
   endfunction

   // State, scan counters and registered display outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         presc  <= '0;
         idx    <= '0;
         hold   <= '0;
         com_q  <= 4'b0001;
         seg_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_d;
         presc  <= presc_d;
         idx    <= idx_d;
         hold   <= hold_d;
         com_q  <= com_d;
         seg_q  <= seg_d;
         busy_q <= busy_d;
      end
   end

   // Next state: scan advance, hold expiry, then grants (which override expiry)
   always_comb begin
      state_d   = state;
      presc_d   = presc;
      idx_d     = idx;
      hold_d    = hold;
      frame_end = (presc == PRESC_LAST) && (idx == 2'd3);

      if (presc == PRESC_LAST) begin
         presc_d = '0;
         idx_d   = idx + 2'd1;
      end else begin
         presc_d = presc + PW'(1);
      end

      if ((state != ST_IDLE) && frame_end) begin
         if (hold == HOLD_LAST) begin
            state_d = ST_IDLE;
            hold_d  = '0;
         end else begin
            hold_d = hold + HW'(1);
         end
      end

      if (req_fail) begin
         state_d = ST_FAIL;
         hold_d  = '0;
         presc_d = '0;
         idx_d   = '0;
      end else if (req_open && (state != ST_FAIL)) begin
         state_d = ST_OPEN;
         hold_d  = '0;
         presc_d = '0;
         idx_d   = '0;
      end

      com_d  = 4'b0001 << idx_d;
      seg_d  = slot_seg(state_d, idx_d, entry_len, entry_digits);
      busy_d = (state_d != ST_IDLE);
   end

   assign {com8, com7, com6, com5}  = com_q;
   assign {a, b, c, d, e, f, g}     = seg_q;
   assign busy                      = busy_q;

endmodule

// File: tb/tb_disp_msg_sched.sv
// Bench for disp_msg_sched: cycle-level message/scan model compared every cycle,
// plus directed checks with hand-computed glyphs and durations.
module tb_disp_msg_sched;

   localparam int unsigned SCAN = 2;
   localparam int unsigned HOLD = 3;
   localparam int MSG_LEN = HOLD * 4 * SCAN;

   localparam logic [6:0] G_O = 7'b1111110;
   localparam logic [6:0] G_F = 7'b1000111;
   localparam logic [6:0] G_DASH = 7'b0000001;

   logic clk, rst, req_open, req_fail;
   logic [2:0]  entry_len;
   logic [15:0] entry_digits;

   logic m_c5, m_c6, m_c7, m_c8, m_a, m_b, m_c, m_d, m_e, m_f, m_g, m_busy;
   logic n_c5, n_c6, n_c7, n_c8, n_a, n_b, n_c, n_d, n_e, n_f, n_g, n_busy;

   disp_msg_sched #(.SCAN_DIV(SCAN), .HOLD_FRAMES(HOLD), .MASK(1)) dut (
      .clk(clk), .rst(rst), .req_open(req_open), .req_fail(req_fail),
      .entry_len(entry_len), .entry_digits(entry_digits),
      .com5(m_c5), .com6(m_c6), .com7(m_c7), .com8(m_c8),
      .a(m_a), .b(m_b), .c(m_c), .d(m_d), .e(m_e), .f(m_f), .g(m_g), .busy(m_busy));

   disp_msg_sched #(.SCAN_DIV(SCAN), .HOLD_FRAMES(HOLD), .MASK(0)) dut_nm (
      .clk(clk), .rst(rst), .req_open(req_open), .req_fail(req_fail),
      .entry_len(entry_len), .entry_digits(entry_digits),
      .com5(n_c5), .com6(n_c6), .com7(n_c7), .com8(n_c8),
      .a(n_a), .b(n_b), .c(n_c), .d(n_d), .e(n_e), .f(n_f), .g(n_g), .busy(n_busy));

   wire [3:0] com_m = {m_c8, m_c7, m_c6, m_c5};
   wire [6:0] seg_m = {m_a, m_b, m_c, m_d, m_e, m_f, m_g};
   wire [3:0] com_n = {n_c8, n_c7, n_c6, n_c5};
   wire [6:0] seg_n = {n_a, n_b, n_c, n_d, n_e, n_f, n_g};

   int chk_cnt = 0;
   int pass_cnt = 0;
   bit cmp_en = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   // Model: message kind, cycles since scan restart, cycles into message
   int m_kind, m_scan, m_msg;
   logic [2:0]  m_len;
   logic [15:0] m_dig;
   logic [6:0] open_g [4] = '{7'b1111110, 7'b1100111, 7'b1001111, 7'b0010101};
   logic [6:0] fail_g [4] = '{7'b1000111, 7'b1110111, 7'b0110000, 7'b0001110};
   logic [6:0] bcd_g [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_kind <= 0; m_scan <= 0; m_msg <= 0; m_len <= '0; m_dig <= '0;
      end else begin
         if (req_fail) begin
            m_kind <= 2; m_scan <= 0; m_msg <= 0;
         end else if (req_open && m_kind != 2) begin
            m_kind <= 1; m_scan <= 0; m_msg <= 0;
         end else begin
            m_scan <= m_scan + 1;
            if (m_kind != 0) begin
               if (m_msg + 1 == MSG_LEN) begin
                  m_kind <= 0; m_msg <= 0;
               end else begin
                  m_msg <= m_msg + 1;
               end
            end
         end
         m_len <= entry_len;
         m_dig <= entry_digits;
      end
   end

   function automatic logic [11:0] model_out(input bit mask);
      int ix, le;
      logic [6:0] s;
      logic [3:0] nib;
      ix = (m_scan / SCAN) % 4;
      s = 7'b0;
      if (m_kind == 1) s = open_g[ix];
      else if (m_kind == 2) s = fail_g[ix];
      else begin
         le = (m_len > 4) ? 4 : int'(m_len);
         if (ix < le) begin
            nib = m_dig[ix*4 +: 4];
            s = mask ? G_DASH : bcd_g[nib];
         end
      end
      return {m_kind != 0, 4'(1 << ix), s};
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_mask1", {20'b0, m_busy, com_m, seg_m}, {20'b0, model_out(1'b1)});
         check("model_mask0", {20'b0, n_busy, com_n, seg_n}, {20'b0, model_out(1'b0)});
      end
   end

   task automatic wait_com(input int k);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (com_m != 4'(1 << k) && n < 20);
      check("wait_com", {28'b0, com_m}, 32'(1 << k));
   endtask

   // Count busy cycles from the current one; optionally inject a request at cycle pulse_at
   task automatic run_msg(input int pulse_at, input logic p_open, input logic p_fail,
                          output int n, output logic [11:0] snap);
      n = 0;
      snap = '0;
      while (m_busy && n < 200) begin
         n++;
         if (n == pulse_at) begin req_open = p_open; req_fail = p_fail; end
         if (n == pulse_at + 1) snap = {m_busy, com_m, seg_m};
         @(negedge clk);
         req_open = 1'b0; req_fail = 1'b0;
      end
   endtask

   task automatic pulse(input logic po, input logic pf);
      req_open = po; req_fail = pf;
      @(negedge clk);
      req_open = 1'b0; req_fail = 1'b0;
   endtask

   initial begin
      int n;
      logic [11:0] snap;
      rst = 1'b1; req_open = 1'b0; req_fail = 1'b0;
      entry_len = '0; entry_digits = '0;
      @(negedge clk);
      cmp_en = 1;
      @(negedge clk);
      check("reset_state", {20'b0, m_busy, com_m, seg_m}, {20'b0, 1'b0, 4'b0001, 7'b0});
      rst = 1'b0;

      // Scan rotation: each common high for SCAN cycles
      for (int k = 0; k < 8; k++) begin
         check("scan_rot", {28'b0, com_m}, 32'(1 << ((k / 2) % 4)));
         check("idle_blank", {24'b0, m_busy, seg_m}, 32'b0);
         @(negedge clk);
      end

      // Entry view: digits 7, 0, 12 with three entered
      entry_len = 3'd3; entry_digits = 16'h0C07;
      wait_com(0);
      check("mask1_d0", {25'b0, seg_m}, {25'b0, G_DASH});
      check("mask0_d0", {25'b0, seg_n}, {25'b0, 7'b1110000});
      wait_com(1);
      check("mask0_d1", {25'b0, seg_n}, {25'b0, 7'b1111110});
      wait_com(2);
      check("mask1_d2", {25'b0, seg_m}, {25'b0, G_DASH});
      check("mask0_d2", {25'b0, seg_n}, 32'b0);
      wait_com(3);
      check("mask1_d3", {25'b0, seg_m}, 32'b0);

      // Plain FAIL message
      pulse(1'b0, 1'b1);
      check("fail_first", {20'b0, m_busy, com_m, seg_m}, {20'b0, 1'b1, 4'b0001, G_F});
      run_msg(0, 1'b0, 1'b0, n, snap);
      check("fail_len", n, 24);
      check("fail_after", {31'b0, m_busy}, 32'b0);

      // Simultaneous requests, then an ignored open
      repeat (3) @(negedge clk);
      pulse(1'b1, 1'b1);
      check("both_fail", {20'b0, m_busy, com_m, seg_m}, {20'b0, 1'b1, 4'b0001, G_F});
      run_msg(5, 1'b1, 1'b0, n, snap);
      check("open_ignored_len", n, 24);

      // OPEN preempted by FAIL at cycle 10
      repeat (2) @(negedge clk);
      pulse(1'b1, 1'b0);
      check("open_first", {20'b0, m_busy, com_m, seg_m}, {20'b0, 1'b1, 4'b0001, G_O});
      run_msg(10, 1'b0, 1'b1, n, snap);
      check("preempt_len", n, 34);
      check("preempt_snap", {20'b0, snap}, {20'b0, 1'b1, 4'b0001, G_F});

      // OPEN retriggered at cycle 10
      repeat (2) @(negedge clk);
      pulse(1'b1, 1'b0);
      run_msg(10, 1'b1, 1'b0, n, snap);
      check("retrig_len", n, 34);
      check("retrig_snap", {20'b0, snap}, {20'b0, 1'b1, 4'b0001, G_O});

      // OPEN retriggered in its expiry cycle
      repeat (2) @(negedge clk);
      pulse(1'b1, 1'b0);
      run_msg(24, 1'b1, 1'b0, n, snap);
      check("expiry_len", n, 48);
      check("expiry_snap", {20'b0, snap}, {20'b0, 1'b1, 4'b0001, G_O});

      // Reset mid-message
      repeat (3) @(negedge clk);
      pulse(1'b0, 1'b1);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("rst_mid", {20'b0, m_busy, com_m, seg_m}, {20'b0, 1'b0, 4'b0001, 7'b0});
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_after", {31'b0, m_busy}, 32'b0);
      repeat (10) @(negedge clk);

      cmp_en = 0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/disp_msg_sched.md
# disp_msg_sched

Display scheduler for the doorlock's 4-digit, 7-segment display. It arbitrates between the keypad-entry view and the timed "OPEN" / "FAIL" result messages, and holds each message for a fixed number of frames. It also owns the digit-scan counter and drives the digit commons and segment lines directly. It sits between the lock FSM (request pulses, entry digits) and the board display pins.

## Interface
- SCAN_DIV, default 4096: clk cycles per digit slot (≥1).
- HOLD_FRAMES, default 256: full 4-digit frames each result message is held (≥1).
- MASK, default 1: 1 = entered digits shown as "-" (segment g only); 0 = digit value decoded.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_open  in  1  single-cycle pulse: show "OPEN".
- req_fail  in  1  single-cycle pulse: show "FAIL".
- entry_len  in  3  entered digit count, 0..4 (values >4 treated as 4).
- entry_digits  in  16  BCD digits; [3:0] is digit 0 (com5), [15:12] is digit 3 (com8).
- com5, com6, com7, com8  out  1 each  digit commons, active-high, one-hot while scanning.
- a, b, c, d, e, f, g  out  1 each  segments, active-high.
- busy  out  1  high while a result message is held.

## Operation
- States:
  - IDLE: entry view.
  - SHOW_OPEN: open message held.
  - SHOW_FAIL: fail message held.
  - Reset state is IDLE.
- Scan: prescaler counts 0..SCAN_DIV-1. At wrap, the 2-bit digit index advances 0→1→2→3→0. Index 0/1/2/3 drives com5/com6/com7/com8; exactly one com is high in every cycle after reset.
- Frame = 4 digit slots = 4·SCAN_DIV cycles. Frame end is the cycle where the index wraps 3→0.
- Glyphs (segments listed are high):
  - O = abcdef, P = abefg, E = adefg, n = ceg.
  - F = aefg, A = abcefg, I = bc, L = def.
  - "-" = g.
  - Blank = none.
- SHOW_OPEN displays O,P,E,n on com5..com8. SHOW_FAIL displays F,A,I,L.
- IDLE: digit k is shown iff k < entry_len. A shown digit is "-" if MASK=1, otherwise its BCD decode; nibbles >9 display blank. Unshown digits are blank.
- Grant rules, evaluated each cycle:
  - req_fail in any state: enter SHOW_FAIL, clear the hold counter, zero the prescaler and the index.
  - req_open in IDLE or SHOW_OPEN: enter or restart SHOW_OPEN, same clearing.
  - req_open in SHOW_FAIL: ignored and not queued.
  - req_open and req_fail in the same cycle: fail wins; open is dropped.
- Hold: the hold counter increments at each frame end in a SHOW state. When it reaches HOLD_FRAMES, the state returns to IDLE and the counter clears. The scan continues uninterrupted.
- busy = (state != IDLE).
- Outputs are a Moore decode of the state, index and registered entry data only. entry_len and entry_digits are registered each cycle. There is no combinational path from any input to any output.

## Timing
- Reset, asserted or released asynchronously:
  - state IDLE, prescaler 0, index 0, hold counter 0, entry registers 0.
  - com5=1, com6..com8=0, all segments 0, busy=0.
- Request latency: request high in cycle N → new state, index 0 and message glyph on com5 visible in cycle N+1. busy rises in N+1.
- Message duration is exactly HOLD_FRAMES·4·SCAN_DIV cycles from the first message cycle. The cycle after that shows the IDLE view, with busy=0.
- The entry view lags its inputs by 1 cycle.
- A restart (retrigger or preemption) takes effect at the grant cycle: the full duration is counted again and the scan restarts at com5.
- A request arriving in the same cycle as hold expiry is granted; the grant takes priority over the return to IDLE.
- rst mid-message aborts it immediately; no request is remembered.
- Counter widths are $clog2-sized. The hold counter is compared by equality and never wraps.

## Test plan
- Reset, then release with SCAN_DIV=2 → com5..com8 each high for 2 cycles in rotation; segments 0; busy 0.
- entry_len=3, MASK=1 → com5..com7 show g only; com8 blank. With MASK=0 and digits 7,0,12 → com5 abc, com6 abcdef, com7 blank.
- SCAN_DIV=2, HOLD_FRAMES=3, req_fail pulse → FAIL visible the next cycle; busy high exactly 24 cycles; then IDLE view.
- req_open and req_fail in the same cycle → FAIL shown. req_open 5 cycles later → ignored; FAIL still ends at cycle 24.
- SHOW_OPEN, then req_fail at cycle 10 → FAIL from cycle 11 for a full 24 cycles, index restarted at com5. req_open at cycle 10 instead → OPEN restarted for 24 cycles.
- rst asserted mid-message for 1 cycle → outputs at reset values immediately; IDLE after release; busy 0.
